// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle execute/write-back stage that sits between the instruction
// decoder and a single-port register file. One ALU micro-op is accepted at a
// time. Its source registers are read one after the other through the shared
// address port. The result is then computed and written back to the
// destination register.
//
// Optional feature macro: ALU_SEQ_CMP_EN
//   defined   : opcode 7 is CMP. It reads both sources and computes A-B.
//               Flags are updated as for SUB, and no register write is made.
//   undefined : opcode 7 is a NOP. It makes no reads and no write.
//               res_data is 0 and the flags are left unchanged.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   op_valid/op_ready micro-op handshake; op_ready is high only in IDLE
//   op_code           0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 LDI, 7 CMP/NOP
//   op_dst/op_src_a/op_src_b/op_imm  micro-op fields, captured on accept
//   rf_write_enable/rf_address/rf_write_data/rf_read_data  register file port
//   res_valid/res_data  one-cycle completion pulse with the result
//   flag_zero/flag_carry  status of the last completed op
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [ADDR_WIDTH-1:0] op_dst,
    input  logic [ADDR_WIDTH-1:0] op_src_a,
    input  logic [ADDR_WIDTH-1:0] op_src_b,
    input  logic [DATA_WIDTH-1:0] op_imm,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  flag_zero,
    output logic                  flag_carry
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

`ifdef ALU_SEQ_CMP_EN
    localparam logic CMP_EN = 1'b1;
`else
    localparam logic CMP_EN = 1'b0;
`endif

    localparam logic [DATA_WIDTH:0]   ALU_ZERO  = {(DATA_WIDTH+1){1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_A   = 3'd1,
        ST_RD_A_W = 3'd2,
        ST_RD_B   = 3'd3,
        ST_RD_B_W = 3'd4,
        ST_EXEC   = 3'd5,
        ST_WB     = 3'd6
    } state_t;

    state_t                  state_r;
    logic                    op_ready_r;
    logic [2:0]              code_r;
    logic [ADDR_WIDTH-1:0]   dst_r;
    logic [ADDR_WIDTH-1:0]   src_b_r;
    logic [DATA_WIDTH-1:0]   imm_r;
    logic [DATA_WIDTH-1:0]   opa_r;
    logic [DATA_WIDTH-1:0]   opb_r;
    logic                    carry_r;

    logic [DATA_WIDTH:0]     alu_res_s;
    logic                    writes_s;
    logic                    sets_flags_s;

    assign op_ready = op_ready_r;

    // ALU on the captured operands. The extra top bit carries the ADD carry
    // or the SUB borrow. Logic ops leave it 0.
    always_comb begin
        alu_res_s = ALU_ZERO;
        case (code_r)
            OP_ADD:  alu_res_s = {1'b0, opa_r} + {1'b0, opb_r};
            OP_SUB:  alu_res_s = {1'b0, opa_r} - {1'b0, opb_r};
            OP_AND:  alu_res_s = {1'b0, opa_r & opb_r};
            OP_OR:   alu_res_s = {1'b0, opa_r | opb_r};
            OP_XOR:  alu_res_s = {1'b0, opa_r ^ opb_r};
            OP_NOT:  alu_res_s = {1'b0, ~opa_r};
            OP_LDI:  alu_res_s = {1'b0, imm_r};
            OP_CMP: begin
                if (CMP_EN) begin
                    alu_res_s = {1'b0, opa_r} - {1'b0, opb_r};
                end else begin
                    alu_res_s = ALU_ZERO;
                end
            end
            default: alu_res_s = ALU_ZERO;
        endcase
    end

    // Opcode 7 never writes the register file. It updates the flags only
    // when it is a real CMP.
    always_comb begin
        writes_s     = (code_r != OP_CMP);
        sets_flags_s = (code_r != OP_CMP) || CMP_EN;
    end

    // Sequencer FSM. Every output is registered and is set on the edge that
    // enters the state in which it must be valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            op_ready_r      <= 1'b1;
            code_r          <= 3'd0;
            dst_r           <= ADDR_ZERO;
            src_b_r         <= ADDR_ZERO;
            imm_r           <= DATA_ZERO;
            opa_r           <= DATA_ZERO;
            opb_r           <= DATA_ZERO;
            carry_r         <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_address      <= ADDR_ZERO;
            rf_write_data   <= DATA_ZERO;
            res_valid       <= 1'b0;
            res_data        <= DATA_ZERO;
            flag_zero       <= 1'b0;
            flag_carry      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (op_valid) begin
                        code_r     <= op_code;
                        dst_r      <= op_dst;
                        src_b_r    <= op_src_b;
                        imm_r      <= op_imm;
                        op_ready_r <= 1'b0;
                        // LDI and the NOP form of opcode 7 need no operands.
                        if ((op_code == OP_LDI) || ((op_code == OP_CMP) && !CMP_EN)) begin
                            state_r    <= ST_EXEC;
                            rf_address <= ADDR_ZERO;
                        end else begin
                            state_r    <= ST_RD_A;
                            rf_address <= op_src_a;
                        end
                    end
                end
                ST_RD_A: begin
                    state_r <= ST_RD_A_W;
                end
                ST_RD_A_W: begin
                    // The address has been stable for two cycles, so data
                    // from a 0- or 1-cycle latency register file is valid.
                    opa_r <= rf_read_data;
                    if (code_r == OP_NOT) begin
                        state_r    <= ST_EXEC;
                        rf_address <= ADDR_ZERO;
                    end else begin
                        state_r    <= ST_RD_B;
                        rf_address <= src_b_r;
                    end
                end
                ST_RD_B: begin
                    state_r <= ST_RD_B_W;
                end
                ST_RD_B_W: begin
                    opb_r      <= rf_read_data;
                    state_r    <= ST_EXEC;
                    rf_address <= ADDR_ZERO;
                end
                ST_EXEC: begin
                    state_r         <= ST_WB;
                    carry_r         <= alu_res_s[DATA_WIDTH];
                    rf_address      <= dst_r;
                    rf_write_enable <= writes_s;
                    rf_write_data   <= writes_s ? alu_res_s[DATA_WIDTH-1:0] : DATA_ZERO;
                    res_valid       <= 1'b1;
                    res_data        <= alu_res_s[DATA_WIDTH-1:0];
                end
                ST_WB: begin
                    state_r         <= ST_IDLE;
                    op_ready_r      <= 1'b1;
                    rf_write_enable <= 1'b0;
                    rf_address      <= ADDR_ZERO;
                    rf_write_data   <= DATA_ZERO;
                    res_valid       <= 1'b0;
                    if (sets_flags_s) begin
                        flag_zero  <= (res_data == DATA_ZERO);
                        flag_carry <= carry_r;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    op_ready_r      <= 1'b1;
                    rf_write_enable <= 1'b0;
                    rf_address      <= ADDR_ZERO;
                    rf_write_data   <= DATA_ZERO;
                    res_valid       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer. It includes a register-file model
// with one cycle of read latency. A table of micro-ops with hand-computed
// results is issued in order. Expectations are queued on accept and checked
// by a monitor when res_valid pulses. Hand-written sequences cover reset
// behaviour and an abort in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [1:0] op_dst;
    logic [1:0] op_src_a;
    logic [1:0] op_src_b;
    logic [7:0] op_imm;
    logic       rf_write_enable;
    logic [1:0] rf_address;
    logic [7:0] rf_write_data;
    logic [7:0] rf_read_data;
    logic       res_valid;
    logic [7:0] res_data;
    logic       flag_zero;
    logic       flag_carry;

    alu_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_code         (op_code),
        .op_dst          (op_dst),
        .op_src_a        (op_src_a),
        .op_src_b        (op_src_b),
        .op_imm          (op_imm),
        .rf_write_enable (rf_write_enable),
        .rf_address      (rf_address),
        .rf_write_data   (rf_write_data),
        .rf_read_data    (rf_read_data),
        .res_valid       (res_valid),
        .res_data        (res_data),
        .flag_zero       (flag_zero),
        .flag_carry      (flag_carry)
    );

    typedef struct {
        logic [2:0] code;
        logic [1:0] dst;
        logic [1:0] a;
        logic [1:0] b;
        logic [7:0] imm;
        bit         jit;
        logic       exp_we;
        logic [7:0] exp_res;
        logic       exp_z;
        logic       exp_c;
    } vec_t;

    typedef struct {
        logic       we;
        logic [1:0] dst;
        logic [7:0] res;
        logic       z;
        logic       c;
        int         nr;
        logic [1:0] a;
        logic [1:0] b;
        int         acc;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 0;
    bit   busy     = 0;
    bit   pend     = 0;
    exp_t pend_e;
    exp_t q[$];
    logic rf_clear;
    logic [7:0] rf_mem [0:3];
    vec_t vecs [0:12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model with one cycle of read latency; reads see the old value
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
            rf_read_data <= 8'h00;
        end else begin
            if (rf_write_enable) rf_mem[rf_address] <= rf_write_data;
            rf_read_data <= rf_mem[rf_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nreads(input logic [2:0] c);
        case (c)
            3'd5:    return 1;
            3'd6:    return 0;
`ifdef ALU_SEQ_CMP_EN
            3'd7:    return 2;
`else
            3'd7:    return 0;
`endif
            default: return 2;
        endcase
    endfunction

    function automatic vec_t mk(input logic [2:0] code, input logic [1:0] dst, input logic [1:0] a,
                                input logic [1:0] b, input logic [7:0] imm, input bit jit,
                                input logic we, input logic [7:0] res, input logic z, input logic c);
        vec_t v;
        v.code = code; v.dst = dst; v.a = a; v.b = b; v.imm = imm; v.jit = jit;
        v.exp_we = we; v.exp_res = res; v.exp_z = z; v.exp_c = c;
        return v;
    endfunction

    // Monitor: checks handshake, address schedule, write-back and flags
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (pend) begin
                check("flag_zero", flag_zero, pend_e.z);
                check("flag_carry", flag_carry, pend_e.c);
                pend = 0;
            end
            check("op_ready", op_ready, !busy);
            if (res_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_res_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("latency", cyc - e.acc + 1, 2 + 2 * e.nr);
                    check("wb_we", rf_write_enable, e.we);
                    check("wb_addr", rf_address, e.dst);
                    if (e.we) check("wb_data", rf_write_data, e.res);
                    check("res_data", res_data, e.res);
                    pend_e = e;
                    pend   = 1;
                end
                busy = 0;
            end else begin
                check("we_idle", rf_write_enable, 0);
                if (busy && q.size() > 0) begin
                    int k;
                    logic [1:0] ea;
                    k  = cyc - q[0].acc + 1;
                    ea = 2'd0;
                    if (q[0].nr >= 1 && k <= 2) ea = q[0].a;
                    else if (q[0].nr == 2 && k <= 4) ea = q[0].b;
                    check("rd_addr", rf_address, ea);
                end
            end
        end
    end

    task automatic do_op(input vec_t v);
        exp_t e;
        int   n;
        bit   seen;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", op_ready, 1);
        op_valid = 1'b1; op_code = v.code; op_dst = v.dst;
        op_src_a = v.a;  op_src_b = v.b;   op_imm = v.imm;
        @(posedge clk);
        #1;
        e.we = v.exp_we; e.dst = v.dst; e.res = v.exp_res; e.z = v.exp_z; e.c = v.exp_c;
        e.nr = nreads(v.code); e.a = v.a; e.b = v.b; e.acc = cyc;
        q.push_back(e);
        busy = 1;
        n = 0;
        seen = 0;
        while (n < 40) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1;
                break;
            end
            if (v.jit) begin
                op_code  = 3'($urandom_range(0, 7));
                op_dst   = 2'($urandom_range(0, 3));
                op_src_a = 2'($urandom_range(0, 3));
                op_src_b = 2'($urandom_range(0, 3));
                op_imm   = 8'($urandom_range(0, 255));
            end else begin
                op_valid = 1'b0;
            end
            n++;
        end
        op_valid = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1; rf_clear = 1'b1;
        op_valid = 1'b1; op_code = 3'd6; op_dst = 2'd1;
        op_src_a = 2'd0; op_src_b = 2'd0; op_imm = 8'hAA;
        repeat (3) @(negedge clk);
        check("rst_we", rf_write_enable, 0);
        check("rst_addr", rf_address, 0);
        check("rst_wdata", rf_write_data, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_zero", flag_zero, 0);
        check("rst_carry", flag_carry, 0);
        check("rst_ready", op_ready, 1);
        reset = 1'b0; rf_clear = 1'b0; op_valid = 1'b0;
        mon_en = 1;

        vecs[0]  = mk(3'd6, 2'd0, 2'd0, 2'd0, 8'h05, 0, 1'b1, 8'h05, 1'b0, 1'b0);
        vecs[1]  = mk(3'd6, 2'd1, 2'd0, 2'd0, 8'hFB, 0, 1'b1, 8'hFB, 1'b0, 1'b0);
        vecs[2]  = mk(3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 0, 1'b1, 8'h00, 1'b1, 1'b1);
        vecs[3]  = mk(3'd1, 2'd3, 2'd0, 2'd1, 8'h00, 0, 1'b1, 8'h0A, 1'b0, 1'b1);
        vecs[4]  = mk(3'd5, 2'd0, 2'd0, 2'd0, 8'h00, 0, 1'b1, 8'hFA, 1'b0, 1'b0);
`ifdef ALU_SEQ_CMP_EN
        vecs[5]  = mk(3'd7, 2'd1, 2'd1, 2'd1, 8'h00, 0, 1'b0, 8'h00, 1'b1, 1'b0);
`else
        vecs[5]  = mk(3'd7, 2'd1, 2'd1, 2'd1, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0);
`endif
        vecs[6]  = mk(3'd2, 2'd3, 2'd0, 2'd1, 8'h00, 0, 1'b1, 8'hFA, 1'b0, 1'b0);
        vecs[7]  = mk(3'd3, 2'd1, 2'd3, 2'd2, 8'h00, 0, 1'b1, 8'hFA, 1'b0, 1'b0);
        vecs[8]  = mk(3'd4, 2'd2, 2'd1, 2'd0, 8'h00, 0, 1'b1, 8'h00, 1'b1, 1'b0);
        vecs[9]  = mk(3'd0, 2'd2, 2'd2, 2'd2, 8'h00, 1, 1'b1, 8'h00, 1'b1, 1'b0);
        vecs[10] = mk(3'd6, 2'd3, 2'd0, 2'd0, 8'hFF, 1, 1'b1, 8'hFF, 1'b0, 1'b0);
        vecs[11] = mk(3'd0, 2'd1, 2'd3, 2'd3, 8'h00, 0, 1'b1, 8'hFE, 1'b0, 1'b1);
        vecs[12] = mk(3'd1, 2'd0, 2'd2, 2'd3, 8'h00, 0, 1'b1, 8'h01, 1'b0, 1'b1);

        for (int i = 0; i < 13; i++) do_op(vecs[i]);

        // Abort ADD r2,r0,r1 during RD_B_W: no write may happen, flags clear.
        @(negedge clk);
        check("abort_ready", op_ready, 1);
        op_valid = 1'b1; op_code = 3'd0; op_dst = 2'd2; op_src_a = 2'd0; op_src_b = 2'd1;
        @(posedge clk);
        #1;
        mon_en = 0;
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_rdbw_addr", rf_address, 2'd1);
        check("abort_busy", op_ready, 0);
        reset = 1'b1;
        #1;
        check("abort_we", rf_write_enable, 0);
        check("abort_ready_rst", op_ready, 1);
        check("abort_carry", flag_carry, 0);
        check("abort_zero", flag_zero, 0);
        check("abort_res_valid", res_valid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        busy = 0;
        pend = 0;
        mon_en = 1;
        repeat (8) @(negedge clk);

        do_op(mk(3'd6, 2'd2, 2'd0, 2'd0, 8'h33, 0, 1'b1, 8'h33, 1'b0, 1'b0));
        repeat (3) @(negedge clk);

        check("queue_empty", q.size(), 0);
        check("rf_r0", rf_mem[0], 8'h01);
        check("rf_r1", rf_mem[1], 8'hFE);
        check("rf_r2", rf_mem[2], 8'h33);
        check("rf_r3", rf_mem[3], 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle execute/write-back stage directly upstream of the single-port register_file; it also consumes register_file read data.
- Accepts one ALU micro-op at a time. Reads up to two source registers sequentially through the single address port, computes the result, and writes it back to the destination register.
- Sole master of the register file port. Sits between the instruction decoder and register_file.

Parameters:
- DATA_WIDTH, 8, width of register contents, operands and result.
- ADDR_WIDTH, 2, register address width (1<<ADDR_WIDTH registers).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  micro-op present.
- op_ready  out  1  sequencer can accept a micro-op.
- op_code  in  3  operation select.
- op_dst  in  ADDR_WIDTH  destination register.
- op_src_a  in  ADDR_WIDTH  source A register.
- op_src_b  in  ADDR_WIDTH  source B register.
- op_imm  in  DATA_WIDTH  immediate for LDI.
- rf_write_enable  out  1  to register_file write_enable.
- rf_address  out  ADDR_WIDTH  to register_file address.
- rf_write_data  out  DATA_WIDTH  to register_file write_data.
- rf_read_data  in  DATA_WIDTH  from register_file read_data.
- res_valid  out  1  one-cycle pulse: micro-op completed.
- res_data  out  DATA_WIDTH  result, valid while res_valid is high.
- flag_zero  out  1  last result == 0.
- flag_carry  out  1  carry (ADD) / borrow (SUB) of last arithmetic op.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high (clk, reset).
- Reset state: FSM=IDLE; rf_write_enable, rf_address, rf_write_data, res_valid, res_data, flag_zero, flag_carry all 0.
- op_ready: equals (state==IDLE). op_valid is ignored while reset is high.
- Accept: op_valid&&op_ready at a rising edge. op_code/dst/src_a/src_b/imm are captured into internal registers; inputs may change afterwards.
- Opcodes: 0 ADD A+B, 1 SUB A-B, 2 AND, 3 OR, 4 XOR, 5 NOT A (unary), 6 LDI imm (no reads), 7 CMP (optional, see below).
- States: IDLE, RD_A, RD_A_W, RD_B, RD_B_W, EXEC, WB.
- Binary ops path: IDLE->RD_A->RD_A_W->RD_B->RD_B_W->EXEC->WB->IDLE.
- NOT path: RD_A->RD_A_W->EXEC.
- LDI path: IDLE->EXEC.
- Read timing:
  - rf_address=src_a throughout RD_A and RD_A_W; rf_read_data is captured at the end of RD_A_W. Likewise src_b for RD_B/RD_B_W.
  - Two-cycle hold tolerates a 0- or 1-cycle register_file read latency.
- EXEC: result computed from captured operands into DATA_WIDTH+1 bits.
  - ADD carry = bit DATA_WIDTH of the sum.
  - SUB carry = borrow (A<B unsigned).
  - Result truncated to DATA_WIDTH, wraps modulo 2^DATA_WIDTH.
  - Logic ops, NOT and LDI force carry 0.
- WB (exactly one cycle): rf_write_enable=1, rf_address=dst, rf_write_data=result, res_valid=1, res_data=result. flag_zero and flag_carry update at the WB->IDLE edge and hold until the next completion.
- rf_write_enable is 0 in every state except WB.
- rf_address is 0 in IDLE and EXEC.
- Latency (accept edge = edge 0):
  - Binary op: WB in cycle 6, op_ready high in cycle 7.
  - NOT: WB in cycle 4.
  - LDI: WB in cycle 2.
  - Back-to-back accept is possible on the first IDLE cycle.
- dst equal to a source: legal. Sources are read before the write, so the old value is used.
- Reset mid-operation: immediate return to IDLE. A pending write is dropped (rf_write_enable deasserts asynchronously). Flags clear.

Optional Feature:
- Macro: ALU_SEQ_CMP_EN.
- Defined: opcode 7 = CMP. Follows the binary path and computes A-B; flags update exactly as SUB. In WB, rf_write_enable stays 0, res_valid pulses and res_data=A-B.
- Undefined: opcode 7 is a NOP. Path IDLE->EXEC->WB; no reads, no write; res_valid pulses with res_data=0; flags unchanged.

Test Plan:
- LDI r0,0x05 then LDI r1,0xFB -> WB 2 cycles after each accept; rf writes (0,0x05), (1,0xFB); flag_zero=0, flag_carry=0.
- ADD r2,r0,r1 after the loads -> rf_address 0,0 then 1,1; write (2,0x00) in cycle 6; res_data=0x00, flag_zero=1, flag_carry=1; op_ready=0 during cycles 1-6.
- SUB r3,r0,r1 (0x05-0xFB) -> write (3,0x0A), flag_carry=1 (borrow), flag_zero=0. Then NOT r0,r0 -> write (0,0xFA), WB in cycle 4.
- CMP r1,r1 -> with ALU_SEQ_CMP_EN: no rf write, res_data=0x00, flag_zero=1, flag_carry=0. Without the macro: no reads, res_data=0, flags unchanged.
- Assert reset during RD_B_W of ADD -> FSM to IDLE, rf_write_enable never pulses, flags 0, op_ready=1. Re-issue LDI r2,0x33 after release -> write (2,0x33).
- Hold op_valid=1 with changing fields across a running op -> only the fields present at the accept edge are used; the next op is accepted on the first IDLE cycle.
